// File: rtl/count_scheduler.sv
// Round-robin owner of a shared mod-11 counter: grants one requester at a time,
// enables the counter for its requested tick count, then pulses done.
module count_scheduler #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   req,
  input  logic [4*N-1:0] len,
  input  logic [3:0]     count,
  output logic           start_n,
  output logic [N-1:0]   grant,
  output logic [N-1:0]   done,
  output logic           busy
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, state_d;
  logic [IW-1:0] owner, owner_d, last, last_d, pick;
  logic [3:0]    target, target_d, pick_len, eff_len;
  logic [4:0]    sum;
  logic [N-1:0]  grant_d, done_d;
  logic          busy_d, found;
  int            idx;

  function automatic logic [N-1:0] onehot(input logic [IW-1:0] i);
    onehot    = '0;
    onehot[i] = 1'b1;
  endfunction

  // First requester at or after last+1, wrapping, so the previous owner goes last.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no latch is inferred.
    pick  = last;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(last) + k) % N;
      if (!found && req[idx]) begin
        pick  = IW'(idx);
        found = 1'b1;
      end
    end
  end

  assign pick_len = len[4*int'(pick) +: 4];
  assign eff_len  = (pick_len == 4'd0) ? 4'd1 : (pick_len > 4'd10) ? 4'd10 : pick_len;
  assign sum      = {1'b0, count} + {1'b0, eff_len};

  // Counter runs only while the owner is still requesting and the stop value is not reached.
  assign start_n = !((state == RUN) && req[owner] && (count != target));

  always_comb begin
    state_d  = state;
    owner_d  = owner;
    target_d = target;
    last_d   = last;
    grant_d  = '0;
    done_d   = '0;
    busy_d   = 1'b0;
    unique case (state)
      IDLE: begin
        if (found) begin
          owner_d  = pick;
          target_d = (sum > 5'd10) ? 4'(sum - 5'd11) : sum[3:0];
          grant_d  = onehot(pick);
          busy_d   = 1'b1;
          state_d  = RUN;
        end
      end
      RUN: begin
        if (!req[owner]) begin
          // Abort wins over completion; the next search starts after this owner.
          last_d  = owner;
          state_d = IDLE;
        end else if (count == target) begin
          grant_d = onehot(owner);
          done_d  = onehot(owner);
          busy_d  = 1'b1;
          state_d = DONE;
        end else begin
          grant_d = onehot(owner);
          busy_d  = 1'b1;
        end
      end
      DONE: begin
        last_d  = owner;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      owner  <= '0;
      target <= '0;
      last   <= IW'(N - 1);
      grant  <= '0;
      done   <= '0;
      busy   <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register updates from pre-edge values.
      state  <= state_d;
      owner  <= owner_d;
      target <= target_d;
      last   <= last_d;
      grant  <= grant_d;
      done   <= done_d;
      busy   <= busy_d;
    end
  end

endmodule

// File: tb/tb_count_scheduler.sv
// Directed bench for count_scheduler: models the shared mod-11 counter and
// checks grant/done/start_n timing, round-robin order, clamping, abort and reset.
module tb_count_scheduler;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   req = '0;
  logic [4*N-1:0] len = '0;
  logic [3:0]     count = 4'd0;
  logic           start_n;
  logic [N-1:0]   grant, done;
  logic           busy;

  logic           load_en = 1'b0;
  logic [3:0]     load_val = 4'd0;

  int n_pass = 0;
  int n_total = 0;

  int cyc = 0;
  int tick_cnt = 0;
  int done_ev = 0;
  int grant_ev = 0;
  int multi_grant = 0;
  int grant_who [64];
  int grant_t [64];
  int done_t [64];
  logic [N-1:0] prev_grant = '0;

  count_scheduler #(.N(N)) dut (
    .clk(clk), .reset(reset), .req(req), .len(len), .count(count),
    .start_n(start_n), .grant(grant), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  // Shared counter: increments on every edge where start_n is low, 10 wraps to 0.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (load_en) count <= load_val;
    else if (!start_n) count <= (count == 4'd10) ? 4'd0 : count + 4'd1;
  end

  function automatic int idx_of(input logic [N-1:0] g);
    idx_of = -1;
    for (int i = 0; i < N; i++) if (g[i]) idx_of = i;
  endfunction

  always @(negedge clk) begin
    if (!start_n) tick_cnt <= tick_cnt + 1;
    if (done != '0) begin
      if (done_ev < 64) done_t[done_ev] <= cyc;
      done_ev <= done_ev + 1;
    end
    if ($countones(grant) > 1) multi_grant <= multi_grant + 1;
    if (grant != '0 && prev_grant == '0) begin
      if (grant_ev < 64) begin
        grant_t[grant_ev]   <= cyc;
        grant_who[grant_ev] <= idx_of(grant);
      end
      grant_ev <= grant_ev + 1;
    end
    prev_grant <= grant;
    if (!reset && count > 4'd10) $error("count out of range: %0d", count);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_count(input logic [3:0] v);
    load_val = v;
    load_en  = 1'b1;
    tick();
    load_en  = 1'b0;
  endtask

  task automatic test_reset();
    tick();
    tick();
    n_total++; if (grant !== '0) $display("FAIL reset_grant: got %b want 0000", grant); else n_pass++;
    n_total++; if (done !== '0) $display("FAIL reset_done: got %b want 0000", done); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_total++; if (start_n !== 1'b1) $display("FAIL reset_start_n: got %b want 1", start_n); else n_pass++;
    reset = 1'b0;
    tick();
  endtask

  // One isolated request: grant timing, exact tick count, stop value, single done pulse.
  task automatic run_one(input string name, input int who, input logic [3:0] l,
                         input logic [3:0] start, input logic [3:0] exp_target,
                         input int exp_ticks);
    int tbase, dbase;
    logic [N-1:0] exp_g;
    exp_g = '0;
    exp_g[who] = 1'b1;
    load_count(start);
    tbase = tick_cnt;
    dbase = done_ev;
    len = '0;
    len[4*who +: 4] = l;
    req = exp_g;
    tick();
    n_total++; if (grant !== exp_g || busy !== 1'b1)
      $display("FAIL %s_grant: got grant=%b busy=%b want grant=%b busy=1", name, grant, busy, exp_g); else n_pass++;
    n_total++; if (start_n !== 1'b0) $display("FAIL %s_start: got start_n=%b want 0", name, start_n); else n_pass++;
    for (int i = 0; i < 30 && done == '0; i++) tick();
    n_total++; if (done !== exp_g || grant !== exp_g)
      $display("FAIL %s_done: got done=%b grant=%b want %b", name, done, grant, exp_g); else n_pass++;
    n_total++; if (count !== exp_target || start_n !== 1'b1)
      $display("FAIL %s_stop: got count=%0d start_n=%b want count=%0d start_n=1", name, count, start_n, exp_target); else n_pass++;
    req = '0;
    tick();
    n_total++; if (grant !== '0 || busy !== 1'b0 || done !== '0)
      $display("FAIL %s_release: got grant=%b busy=%b done=%b want all 0", name, grant, busy, done); else n_pass++;
    n_total++; if (tick_cnt - tbase !== exp_ticks)
      $display("FAIL %s_ticks: got %0d want %0d", name, tick_cnt - tbase, exp_ticks); else n_pass++;
    n_total++; if (done_ev - dbase !== 1)
      $display("FAIL %s_done_count: got %0d want 1", name, done_ev - dbase); else n_pass++;
  endtask

  task automatic test_round_robin();
    int gbase, dbase;
    int exp_order [5] = '{0, 1, 2, 3, 0};
    gbase = grant_ev;
    dbase = done_ev;
    len = {4'd2, 4'd2, 4'd2, 4'd2};
    req = 4'b1111;
    for (int i = 0; i < 100 && done_ev < dbase + 5; i++) tick();
    req = '0;
    tick();
    tick();
    n_total++; if (grant_ev - gbase !== 5)
      $display("FAIL rr_grant_count: got %0d want 5", grant_ev - gbase); else n_pass++;
    for (int k = 0; k < 5; k++) begin
      n_total++; if (grant_who[gbase + k] !== exp_order[k])
        $display("FAIL rr_order_%0d: got %0d want %0d", k, grant_who[gbase + k], exp_order[k]); else n_pass++;
    end
    for (int k = 0; k < 4; k++) begin
      n_total++; if (!(done_t[dbase + k] < grant_t[gbase + k + 1]))
        $display("FAIL rr_done_before_grant_%0d: done at %0d grant at %0d", k, done_t[dbase + k], grant_t[gbase + k + 1]); else n_pass++;
    end
    n_total++; if (multi_grant !== 0)
      $display("FAIL rr_onehot: got %0d multi-bit grant cycles want 0", multi_grant); else n_pass++;
  endtask

  task automatic test_abort();
    int tbase, dbase;
    load_count(4'd2);
    tbase = tick_cnt;
    dbase = done_ev;
    len = {4'd1, 4'd0, 4'd8, 4'd1};
    req = 4'b1011;
    tick();
    n_total++; if (grant !== 4'b0010) $display("FAIL abort_grant: got %b want 0010", grant); else n_pass++;
    tick(); tick(); tick();
    req = 4'b1001;
    #1;
    n_total++; if (start_n !== 1'b1) $display("FAIL abort_start_n: got %b want 1", start_n); else n_pass++;
    n_total++; if (count !== 4'd5) $display("FAIL abort_count: got %0d want 5", count); else n_pass++;
    tick();
    n_total++; if (grant !== '0 || done !== '0 || count !== 4'd5)
      $display("FAIL abort_idle: got grant=%b done=%b count=%0d want 0000 0000 5", grant, done, count); else n_pass++;
    n_total++; if (tick_cnt - tbase !== 3) $display("FAIL abort_ticks: got %0d want 3", tick_cnt - tbase); else n_pass++;
    tick();
    n_total++; if (grant !== 4'b1000) $display("FAIL abort_next_owner: got %b want 1000", grant); else n_pass++;
    n_total++; if (done_ev !== dbase) $display("FAIL abort_no_done: got %0d pulses want 0", done_ev - dbase); else n_pass++;
    for (int i = 0; i < 20 && done == '0; i++) tick();
    n_total++; if (done !== 4'b1000) $display("FAIL abort_next_done: got %b want 1000", done); else n_pass++;
    req = '0;
    tick();
    tick();
  endtask

  task automatic test_reset_mid_run();
    load_count(4'd0);
    len = {4'd0, 4'd10, 4'd0, 4'd1};
    req = 4'b0100;
    tick();
    n_total++; if (grant !== 4'b0100) $display("FAIL rst_run_grant: got %b want 0100", grant); else n_pass++;
    tick();
    tick();
    reset = 1'b1;
    #1;
    n_total++; if (grant !== '0 || busy !== 1'b0 || done !== '0 || start_n !== 1'b1)
      $display("FAIL rst_run_clear: got grant=%b busy=%b done=%b start_n=%b want 0 0 0 1", grant, busy, done, start_n); else n_pass++;
    req = 4'b0101;
    tick();
    reset = 1'b0;
    tick();
    n_total++; if (grant !== 4'b0001) $display("FAIL rst_run_first_owner: got %b want 0001", grant); else n_pass++;
    req = '0;
    tick();
    tick();
  endtask

  initial begin
    test_reset();
    run_one("single", 0, 4'd3, 4'd0, 4'd3, 3);
    run_one("wrap", 2, 4'd5, 4'd9, 4'd3, 5);
    run_one("len_zero", 1, 4'd0, 4'd10, 4'd0, 1);
    run_one("len_max", 3, 4'd15, 4'd4, 4'd3, 10);
    test_round_robin();
    test_abort();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/count_scheduler.md
# count_scheduler

Round-robin scheduler that shares one mod-11 (0..10) up-counter between N requesters. Each requester asks for a run of 1..10 counter ticks. The scheduler grants the counter to one requester at a time and drives the counter's active-low enable for exactly that many ticks. It computes the stop value with mod-11 arithmetic from the counter's current value, then pulses `done` to the owner. It sits between the requesting blocks and the shared counter, and is the only driver of the counter's enable.

## Interface
- `N`, default 4: number of requesters, 2..8.
- `clk`  in  1: clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-high; clock `clk`.
- `req`  in  N: request per requester; level, held until `done` or withdrawn.
- `len`  in  4*N: requested tick count, requester i at bits [4i+3:4i].
- `count`  in  4: current value of the shared counter, 0..10.
- `start_n`  out  1: counter enable, active-low; the counter increments (10 wraps to 0) on every edge where it is 0.
- `grant`  out  N: one-hot owner; all zero when idle.
- `done`  out  N: one-cycle completion pulse to the owner.
- `busy`  out  1: high in RUN and DONE.

## Operation
- States: IDLE, RUN, DONE.
- **IDLE**
  - `start_n` = 1, `grant` = 0.
  - If any `req` bit is set, select the first set bit searching upward (with wrap) from `last`+1, where `last` is the index of the previous owner.
  - Latch `owner`, and latch `target` = (`count` + L) mod 11, where L is the effective length.
  - Next state: RUN.
- **Effective length L**
  - `len` = 0 gives L = 1.
  - `len` > 10 gives L = 10.
  - Otherwise L = `len`.
- **Mod-11 arithmetic:** 5-bit sum s = `count` + L (max 20); `target` = s − 11 if s > 10, else s.
- **RUN**
  - `grant[owner]` = 1.
  - `start_n` is combinational: 0 while `count` != `target`, 1 once `count` == `target`. The counter therefore advances exactly L ticks.
  - `count` == `target` gives next state DONE.
  - `req[owner]` = 0 (abort) gives next state IDLE, with no `done` and `start_n` forced to 1 immediately. Abort takes priority over completion in the same cycle.
- **DONE**
  - `done[owner]` = 1 for one cycle, `grant[owner]` still 1, `start_n` = 1.
  - Update `last` := `owner`.
  - Next state: IDLE unconditionally.
- `last` is updated on DONE and also on abort.
- Requests arriving during RUN or DONE wait. No preemption.
- `len` and `count` are sampled only in the IDLE grant cycle. Later changes to `len` are ignored.
- `count` > 10 is illegal. The bench asserts it never occurs; behaviour is undefined.

## Timing
- Reset (asynchronous) forces:
  - state IDLE;
  - `grant` = 0, `done` = 0, `busy` = 0, `start_n` = 1;
  - `owner` = 0, `target` = 0;
  - `last` = N−1, so requester 0 wins first.
- Reset mid-RUN stops the counter immediately (`start_n` = 1) and drops `grant` with no `done`.
- Request sampled at edge e0 in IDLE:
  - `grant` and `busy` rise after e0, and `start_n` falls after e0.
  - Counter increments on e1..eL; `count` == `target` after eL, so `start_n` = 1.
  - State DONE after eL+1, with the `done` pulse.
  - IDLE after eL+2, when `grant` and `busy` fall.
  - `grant` is high L+2 cycles. The next grant is earliest at edge eL+3, giving a minimum period of L+3 cycles per grant.
- `grant`, `done` and `busy` are registered. `start_n` is combinational from the registered state plus `count`.
- The chosen owner is always one-hot.

## Test plan
- **Single request:** `count`=0, `req`=0001, `len0`=3 → `grant`=0001 one cycle later; `start_n` low exactly 3 edges; `count` stops at 3; `done`=0001 one cycle; `grant`=0 after.
- **Wrap-around:** `count`=9, `len`=5 → `target`=3; `count` goes 10,0,1,2,3 then holds; `done` once.
- **Round-robin:** `req`=1111, all `len`=2, held → grant order 0,1,2,3,0; each `done` pulse precedes the next grant; never two `grant` bits set.
- **Clamping:**
  - `len`=0 → exactly 1 tick.
  - `len`=15 from `count`=4 → 10 ticks, `target`=3.
- **Abort:** `len`=8, drop `req` after 3 ticks → `start_n` = 1 that same cycle; `count` frozen at start+3; no `done`; the next requester is served starting after the aborted index.
- **Reset mid-run:** assert `reset` during RUN → `grant`/`busy`/`done` = 0 and `start_n` = 1 immediately; after release, requester 0 wins if requesting.
